// File: rtl/lsu_pkg.sv
// Shared state encoding, funct3 decodes and defaults for the EX-stage load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/lsu_align.sv
// Data-bus alignment helper: misalignment check, byte enables, write-lane replication and
// load lane select/extension. Purely combinational, no flow control.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_ext
);

  logic [31:0] lane;

  always_comb begin
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata_rep  = wdata;
    case (funct3[1:0])
      SB[1:0]: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SH[1:0]: begin
        misaligned = addr_lo[0];
        be         = 4'b0011 << addr_lo;
        wdata_rep  = {2{wdata[15:0]}};
      end
      SW[1:0]: misaligned = |addr_lo;
      default: misaligned = 1'b1;
    endcase
  end

  // Shift the addressed lane down to bit 0 before extending.
  assign lane = rdata >> {addr_lo, 3'b000};

  always_comb begin
    case (funct3)
      LB:      load_ext = {{24{lane[7]}}, lane[7:0]};
      LBU:     load_ext = {24'h0, lane[7:0]};
      LH:      load_ext = {{16{lane[15]}}, lane[15:0]};
      LHU:     load_ext = {16'h0, lane[15:0]};
      LW:      load_ext = rdata;
      default: load_ext = lane;
    endcase
  end

endmodule

// File: rtl/ex_lsu.sv
// EX-stage load/store unit: one outstanding bus access, result in DONE (>= 3 cycles to advance).
// Stalls the pipeline while the access is in flight; DONE holds its result until advance.
module ex_lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ram_load_access,
  input  logic        ram_store_access,
  input  logic [31:0] ram_load_addr,
  input  logic [31:0] ram_store_addr,
  input  logic [31:0] ram_store_data,
  input  logic [2:0]  funct3,
  input  logic        flush,
  input  logic        advance,
  output logic        stall_req,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        misalign_exc,
  output logic        access_fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic [2:0]  f3_q;
  logic [31:0] rdata_q;
  logic [7:0]  tmo_q;
  logic        fault_q, flushed_q;
  logic        active, is_load, in_idle, latch_en, tmo_hit, complete;
  logic [31:0] req_addr;
  logic [1:0]  al_addr_lo;
  logic [2:0]  al_funct3;
  logic        al_mis;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  assign active   = ram_load_access | ram_store_access;
  assign is_load  = ram_load_access;
  assign req_addr = is_load ? ram_load_addr : ram_store_addr;
  assign in_idle  = (state_q == IDLE);

  // One aligner serves both directions: request decode in IDLE, load extension from latches otherwise.
  assign al_addr_lo = in_idle ? req_addr[1:0] : bus_addr[1:0];
  assign al_funct3  = in_idle ? funct3 : f3_q;

  lsu_align u_align (
    .addr_lo    (al_addr_lo),
    .funct3     (al_funct3),
    .wdata      (ram_store_data),
    .rdata      (rdata_q),
    .misaligned (al_mis),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .load_ext   (al_load)
  );

  assign tmo_hit  = (tmo_q == TMO_LAST) && !bus_ready;
  assign complete = bus_ready || tmo_hit;

  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    stall_req    = 1'b0;
    misalign_exc = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    access_fault = 1'b0;
    bus_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (active && !flush) begin
          if (al_mis) begin
            misalign_exc = 1'b1;
          end else begin
            stall_req = 1'b1;
            latch_en  = 1'b1;
            state_d   = ACCESS;
          end
        end
      end
      ACCESS: begin
        bus_req   = 1'b1;
        stall_req = 1'b1;
        // A flushed access still completes on the bus but skips DONE.
        if (complete) state_d = (flushed_q || flush) ? IDLE : DONE;
      end
      DONE: begin
        if (!flush) begin
          access_fault = fault_q;
          if (!bus_we && !fault_q) begin
            load_valid = 1'b1;
            load_data  = al_load;
          end
        end
        if (advance || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      f3_q      <= '0;
      rdata_q   <= '0;
      tmo_q     <= '0;
      fault_q   <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        bus_we    <= !is_load;
        bus_addr  <= req_addr;
        bus_be    <= al_be;
        bus_wdata <= al_wdata;
        f3_q      <= funct3;
        tmo_q     <= '0;
        fault_q   <= 1'b0;
        flushed_q <= 1'b0;
      end
      if (state_q == ACCESS) begin
        if (flush) flushed_q <= 1'b1;
        if (bus_ready)    rdata_q <= bus_rdata;
        else if (tmo_hit) fault_q <= 1'b1;
        else              tmo_q   <= tmo_q + 8'd1;
      end
    end
  end

endmodule
